// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: opcodes, FSM states, access classes
// and the decode helpers used both at request acceptance and in the lane logic.
package mem_access_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2a;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SWR = 6'h2e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    MC_NONE  = 3'd0,
    MC_BYTE  = 3'd1,
    MC_HALF  = 3'd2,
    MC_WORD  = 3'd3,
    MC_LEFT  = 3'd4,
    MC_RIGHT = 3'd5
  } mem_class_t;

  function automatic mem_class_t op_class(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB:   op_class = MC_BYTE;
      OP_LH, OP_LHU, OP_SH:   op_class = MC_HALF;
      OP_LW, OP_SW:           op_class = MC_WORD;
      OP_LWL, OP_SWL:         op_class = MC_LEFT;
      OP_LWR, OP_SWR:         op_class = MC_RIGHT;
      default:                op_class = MC_NONE;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
  endfunction

  // Alignment is judged on the raw address, independent of lane endianness.
  function automatic logic op_misaligned(input logic [5:0] op, input logic [1:0] a);
    mem_class_t c;
    c = op_class(op);
    return ((c == MC_HALF) && a[0]) || ((c == MC_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Combinational lane steering: byte enables and write data placement for stores,
// extraction/extension and LWL/LWR merging for loads.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [5:0]  op,
  input  logic [1:0]  a,
  input  logic [31:0] rt,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [1:0]  e;
  logic [4:0]  sh_e;
  logic [4:0]  sh_l;
  logic [31:0] shr;

  always_comb begin
    if (!BIG_ENDIAN)                e = a;
    else if (op_class(op) == MC_HALF) e = a ^ 2'd2;
    else                            e = a ^ 2'd3;
    sh_e      = {e, 3'b000};
    sh_l      = {~e, 3'b000};   // 8*(3-e)
    shr       = rdata >> sh_e;
    sel       = 4'b0000;
    wdata     = 32'h0;
    load_data = 32'h0;
    case (op)
      OP_LB:  begin sel = 4'b0001 << e; load_data = {{24{shr[7]}}, shr[7:0]}; end
      OP_LBU: begin sel = 4'b0001 << e; load_data = {24'h0, shr[7:0]}; end
      OP_SB:  begin sel = 4'b0001 << e; wdata = {4{rt[7:0]}}; end
      OP_LH:  begin sel = 4'b0011 << e; load_data = {{16{shr[15]}}, shr[15:0]}; end
      OP_LHU: begin sel = 4'b0011 << e; load_data = {16'h0, shr[15:0]}; end
      OP_SH:  begin sel = 4'b0011 << e; wdata = {2{rt[15:0]}}; end
      OP_LW:  begin sel = 4'b1111; load_data = rdata; end
      OP_SW:  begin sel = 4'b1111; wdata = rt; end
      OP_LWL: begin
        sel       = 4'b1111;
        load_data = (rdata << sh_l) | (rt & ~(32'hFFFF_FFFF << sh_l));
      end
      OP_LWR: begin
        sel       = 4'b1111;
        load_data = shr | (rt & ~(32'hFFFF_FFFF >> sh_e));
      end
      OP_SWL: begin sel = 4'b1111 >> ~e; wdata = rt >> sh_l; end
      OP_SWR: begin sel = 4'b1111 << e;  wdata = rt << sh_e; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one request, runs a single bus transfer with ack timeout,
// and reports the result or exception as a one-cycle pulse.
// Handshake: a request transfers on a rising edge where in_valid && in_ready; in_ready
// is high only in IDLE, and op/addr/rt_data are captured on that edge.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           rt_data,
  output logic                  bus_en,
  output logic                  bus_we,
  output logic [3:0]            bus_sel,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wdata,
  input  logic [31:0]           bus_rdata,
  input  logic                  bus_ack,
  output logic                  res_valid,
  output logic [31:0]           res_data,
  output logic                  res_wreg,
  output logic                  exc_adel,
  output logic                  exc_ades,
  output logic                  exc_bus,
  output logic [ADDR_WIDTH-1:0] badvaddr,
  output logic                  busy
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t                state;
  logic [5:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           rt_q;
  logic [CW-1:0]         cnt;
  logic [3:0]            lane_sel;
  logic [31:0]           lane_wdata;
  logic [31:0]           lane_load;
  logic                  load_q;

  mem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .op        (op_q),
    .a         (addr_q[1:0]),
    .rt        (rt_q),
    .rdata     (bus_rdata),
    .sel       (lane_sel),
    .wdata     (lane_wdata),
    .load_data (lane_load)
  );

  assign load_q    = op_is_load(op_q);
  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign bus_en    = (state == ST_BUS);
  assign bus_we    = bus_en && !load_q;
  assign bus_sel   = bus_en ? lane_sel : 4'b0000;
  assign bus_addr  = bus_en ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus_wdata = bus_en ? lane_wdata : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      op_q      <= 6'h0;
      addr_q    <= '0;
      rt_q      <= 32'h0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= 32'h0;
      res_wreg  <= 1'b0;
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;
      exc_bus   <= 1'b0;
      badvaddr  <= '0;
    end else begin
      // Result outputs are pulses: cleared every cycle unless entering DONE.
      res_valid <= 1'b0;
      res_data  <= 32'h0;
      res_wreg  <= 1'b0;
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;
      exc_bus   <= 1'b0;
      badvaddr  <= '0;
      case (state)
        ST_IDLE: if (in_valid) begin
          op_q   <= op;
          addr_q <= addr;
          rt_q   <= rt_data;
          cnt    <= '0;
          if (op_class(op) == MC_NONE) begin
            state     <= ST_DONE;
            res_valid <= 1'b1;
          end else if (op_misaligned(op, addr[1:0])) begin
            state     <= ST_DONE;
            res_valid <= 1'b1;
            exc_adel  <= op_is_load(op);
            exc_ades  <= !op_is_load(op);
            badvaddr  <= addr;
          end else begin
            state <= ST_BUS;
          end
        end
        ST_BUS: begin
          // An ack on the final counted cycle still completes normally.
          if (bus_ack) begin
            state     <= ST_DONE;
            res_valid <= 1'b1;
            res_wreg  <= load_q;
            res_data  <= load_q ? lane_load : 32'h0;
          end else if (cnt == CNT_LAST) begin
            state     <= ST_DONE;
            res_valid <= 1'b1;
            exc_bus   <= 1'b1;
            badvaddr  <= addr_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: little- and big-endian instances share one stimulus stream
// and are compared every cycle against a per-transaction timeline model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] rt_data;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  logic        in_ready_le, bus_en_le, bus_we_le, res_valid_le, res_wreg_le;
  logic        exc_adel_le, exc_ades_le, exc_bus_le, busy_le;
  logic [3:0]  bus_sel_le;
  logic [31:0] bus_addr_le, bus_wdata_le, res_data_le, badvaddr_le;
  logic        in_ready_be, bus_en_be, bus_we_be, res_valid_be, res_wreg_be;
  logic        exc_adel_be, exc_ades_be, exc_bus_be, busy_be;
  logic [3:0]  bus_sel_be;
  logic [31:0] bus_addr_be, bus_wdata_be, res_data_be, badvaddr_be;

  mem_access_unit #(.ADDR_WIDTH(32), .BIG_ENDIAN(1'b0), .TIMEOUT(TO)) dut_le (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_le), .op(op),
    .addr(addr), .rt_data(rt_data), .bus_en(bus_en_le), .bus_we(bus_we_le),
    .bus_sel(bus_sel_le), .bus_addr(bus_addr_le), .bus_wdata(bus_wdata_le),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .res_valid(res_valid_le),
    .res_data(res_data_le), .res_wreg(res_wreg_le), .exc_adel(exc_adel_le),
    .exc_ades(exc_ades_le), .exc_bus(exc_bus_le), .badvaddr(badvaddr_le), .busy(busy_le));

  mem_access_unit #(.ADDR_WIDTH(32), .BIG_ENDIAN(1'b1), .TIMEOUT(TO)) dut_be (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_be), .op(op),
    .addr(addr), .rt_data(rt_data), .bus_en(bus_en_be), .bus_we(bus_we_be),
    .bus_sel(bus_sel_be), .bus_addr(bus_addr_be), .bus_wdata(bus_wdata_be),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .res_valid(res_valid_be),
    .res_data(res_data_be), .res_wreg(res_wreg_be), .exc_adel(exc_adel_be),
    .exc_ades(exc_ades_be), .exc_bus(exc_bus_be), .badvaddr(badvaddr_be), .busy(busy_be));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  bit chk_en  = 1'b0;

  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (act=running exp=finished)");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  function automatic bit m_is_half(input logic [5:0] o);
    return (o == OP_LH) || (o == OP_LHU) || (o == OP_SH);
  endfunction

  function automatic bit m_is_mem(input logic [5:0] o);
    return o inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
                     OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
  endfunction

  function automatic bit m_is_load(input logic [5:0] o);
    return o inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
  endfunction

  function automatic bit m_misal(input logic [5:0] o, input logic [1:0] a);
    return (m_is_half(o) && a[0]) || ((o == OP_LW || o == OP_SW) && a != 2'd0);
  endfunction

  function automatic int m_e(input logic [5:0] o, input logic [1:0] a, input bit be);
    if (!be) return int'(a);
    if (m_is_half(o)) return int'(a ^ 2'd2);
    return int'(a ^ 2'd3);
  endfunction

  function automatic logic [3:0] m_sel(input logic [5:0] o, input logic [1:0] a, input bit be);
    int e;
    e = m_e(o, a, be);
    case (o)
      OP_LB, OP_LBU, OP_SB:             return 4'(1 << e);
      OP_LH, OP_LHU, OP_SH:             return 4'(3 << e);
      OP_LW, OP_SW, OP_LWL, OP_LWR:     return 4'hF;
      OP_SWL:                           return 4'(15 >> (3 - e));
      OP_SWR:                           return 4'(15 << e);
      default:                          return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] o, input logic [1:0] a,
                                          input logic [31:0] rt, input bit be);
    int e;
    e = m_e(o, a, be);
    case (o)
      OP_SB:   return {rt[7:0], rt[7:0], rt[7:0], rt[7:0]};
      OP_SH:   return {rt[15:0], rt[15:0]};
      OP_SW:   return rt;
      OP_SWL:  return rt >> (8 * (3 - e));
      OP_SWR:  return rt << (8 * e);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] o, input logic [1:0] a,
                                         input logic [31:0] rt, input logic [31:0] w, input bit be);
    int e;
    logic [31:0] s;
    e = m_e(o, a, be);
    s = w >> (8 * e);
    case (o)
      OP_LB:   return {{24{s[7]}}, s[7:0]};
      OP_LBU:  return {24'h0, s[7:0]};
      OP_LH:   return {{16{s[15]}}, s[15:0]};
      OP_LHU:  return {16'h0, s[15:0]};
      OP_LW:   return w;
      OP_LWL:  return (w << (8 * (3 - e))) | (rt & ~(32'hFFFF_FFFF << (8 * (3 - e))));
      OP_LWR:  return s | (rt & ~(32'hFFFF_FFFF >> (8 * e)));
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- expected outputs for the current cycle ----------------
  logic        e_in_ready, e_busy, e_bus_en, e_bus_we, e_res_valid, e_res_wreg;
  logic        e_adel, e_ades, e_exc_bus;
  logic [3:0]  e_sel_le, e_sel_be;
  logic [31:0] e_bus_addr, e_wdata_le, e_wdata_be, e_res_le, e_res_be, e_badv;

  task automatic set_idle();
    e_in_ready = 1'b1; e_busy = 1'b0; e_bus_en = 1'b0; e_bus_we = 1'b0;
    e_res_valid = 1'b0; e_res_wreg = 1'b0; e_adel = 1'b0; e_ades = 1'b0; e_exc_bus = 1'b0;
    e_sel_le = 4'h0; e_sel_be = 4'h0; e_bus_addr = 32'h0; e_wdata_le = 32'h0;
    e_wdata_be = 32'h0; e_res_le = 32'h0; e_res_be = 32'h0; e_badv = 32'h0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare + capture ----------------
  int          cap_bus_cycles;
  logic [3:0]  cap_sel_le, cap_sel_be;
  logic [31:0] cap_wdata_le, cap_res_le, cap_res_be, cap_badv;
  logic        cap_adel, cap_exc_bus, cap_wreg;
  int          cap_lat;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready_le", 32'(in_ready_le), 32'(e_in_ready));
      chk("busy_le", 32'(busy_le), 32'(e_busy));
      chk("bus_en_le", 32'(bus_en_le), 32'(e_bus_en));
      chk("bus_we_le", 32'(bus_we_le), 32'(e_bus_we));
      chk("bus_sel_le", 32'(bus_sel_le), 32'(e_sel_le));
      chk("bus_addr_le", bus_addr_le, e_bus_addr);
      chk("bus_wdata_le", bus_wdata_le, e_wdata_le);
      chk("res_valid_le", 32'(res_valid_le), 32'(e_res_valid));
      chk("res_data_le", res_data_le, e_res_le);
      chk("res_wreg_le", 32'(res_wreg_le), 32'(e_res_wreg));
      chk("exc_adel_le", 32'(exc_adel_le), 32'(e_adel));
      chk("exc_ades_le", 32'(exc_ades_le), 32'(e_ades));
      chk("exc_bus_le", 32'(exc_bus_le), 32'(e_exc_bus));
      chk("badvaddr_le", badvaddr_le, e_badv);
      chk("in_ready_be", 32'(in_ready_be), 32'(e_in_ready));
      chk("bus_en_be", 32'(bus_en_be), 32'(e_bus_en));
      chk("bus_we_be", 32'(bus_we_be), 32'(e_bus_we));
      chk("bus_sel_be", 32'(bus_sel_be), 32'(e_sel_be));
      chk("bus_addr_be", bus_addr_be, e_bus_addr);
      chk("bus_wdata_be", bus_wdata_be, e_wdata_be);
      chk("res_valid_be", 32'(res_valid_be), 32'(e_res_valid));
      chk("res_data_be", res_data_be, e_res_be);
      chk("res_wreg_be", 32'(res_wreg_be), 32'(e_res_wreg));
      chk("exc_flags_be", {29'h0, exc_adel_be, exc_ades_be, exc_bus_be},
          {29'h0, e_adel, e_ades, e_exc_bus});
      chk("badvaddr_be", badvaddr_be, e_badv);
    end
    if (bus_en_le) begin
      cap_bus_cycles++;
      cap_sel_le   = bus_sel_le;
      cap_sel_be   = bus_sel_be;
      cap_wdata_le = bus_wdata_le;
    end
    if (res_valid_le) begin
      cap_res_le  = res_data_le;
      cap_res_be  = res_data_be;
      cap_adel    = exc_adel_le;
      cap_exc_bus = exc_bus_le;
      cap_badv    = badvaddr_le;
      cap_wreg    = res_wreg_le;
      cap_lat     = cyc - acc_cyc;
    end
  end

  // ---------------- driver ----------------
  // ack_after: BUS cycle (1-based) in which bus_ack is raised; 0 or >TO means never.
  task automatic run_txn(input logic [5:0] o, input logic [31:0] ad, input logic [31:0] rt,
                         input logic [31:0] rd, input int ack_after);
    int nbus;
    bit ld, mem, mis, acked;
    @(posedge clk); #1;
    set_idle();
    in_valid = 1'b1; op = o; addr = ad; rt_data = rt;
    bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    acc_cyc = cyc; cap_bus_cycles = 0;
    mem = m_is_mem(o); ld = m_is_load(o); mis = mem && m_misal(o, ad[1:0]);
    @(posedge clk); #1;
    in_valid = 1'($urandom_range(0, 1)); op = 6'($urandom); addr = $urandom; rt_data = $urandom;
    if (!mem || mis) begin
      set_idle();
      e_in_ready = 1'b0; e_busy = 1'b1; e_res_valid = 1'b1;
      e_adel = mis && ld; e_ades = mis && !ld; e_badv = mis ? ad : 32'h0;
      bus_ack = 1'($urandom_range(0, 1));
    end else begin
      acked = (ack_after >= 1) && (ack_after <= TO);
      nbus  = acked ? ack_after : TO;
      for (int i = 1; i <= nbus; i++) begin
        if (i > 1) begin
          @(posedge clk); #1;
          in_valid = 1'($urandom_range(0, 1)); op = 6'($urandom);
        end
        set_idle();
        e_in_ready = 1'b0; e_busy = 1'b1; e_bus_en = 1'b1; e_bus_we = !ld;
        e_bus_addr = {ad[31:2], 2'b00};
        e_sel_le = m_sel(o, ad[1:0], 1'b0);  e_sel_be = m_sel(o, ad[1:0], 1'b1);
        e_wdata_le = m_wdata(o, ad[1:0], rt, 1'b0); e_wdata_be = m_wdata(o, ad[1:0], rt, 1'b1);
        bus_ack   = (i == ack_after);
        bus_rdata = (i == ack_after) ? rd : $urandom;
      end
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1)); bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
      set_idle();
      e_in_ready = 1'b0; e_busy = 1'b1; e_res_valid = 1'b1;
      if (acked) begin
        e_res_wreg = ld;
        e_res_le = ld ? m_load(o, ad[1:0], rt, rd, 1'b0) : 32'h0;
        e_res_be = ld ? m_load(o, ad[1:0], rt, rd, 1'b1) : 32'h0;
      end else begin
        e_exc_bus = 1'b1; e_badv = ad;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  logic [5:0] op_tbl [0:13];

  // ---------------- main sequence ----------------
  initial begin
    op_tbl = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
               OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR, 6'h00, 6'h0f};
    rst = 1'b0; in_valid = 1'b0; op = 6'h0; addr = 32'h0; rt_data = 32'h0;
    bus_rdata = 32'h0; bus_ack = 1'b0;
    set_idle();
    cap_bus_cycles = 0;
    #3;
    chk("reset_in_ready", {30'h0, in_ready_le, in_ready_be}, 32'h3);
    chk("reset_busy", {30'h0, busy_le, busy_be}, 32'h0);
    chk("reset_bus_en", {30'h0, bus_en_le, bus_en_be}, 32'h0);
    chk("reset_res_valid", {30'h0, res_valid_le, res_valid_be}, 32'h0);
    chk("reset_bus_sel", 32'(bus_sel_le), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;

    run_txn(OP_LB, 32'h1003, 32'h0, 32'h80AABBCC, 2); settle();
    chk("lb_sel", 32'(cap_sel_le), 32'h8);
    chk("lb_res", cap_res_le, 32'hFFFFFF80);
    chk("lb_latency", cap_lat, 3);

    run_txn(OP_SWL, 32'h2001, 32'h11223344, 32'h0, 1); settle();
    chk("swl_sel", 32'(cap_sel_le), 32'h3);
    chk("swl_wdata", cap_wdata_le, 32'h00001122);
    run_txn(OP_SWR, 32'h2001, 32'h11223344, 32'h0, 1); settle();
    chk("swr_sel", 32'(cap_sel_le), 32'hE);
    chk("swr_wdata", cap_wdata_le, 32'h22334400);

    run_txn(OP_LHU, 32'h10, 32'h0, 32'h1234ABCD, 1); settle();
    chk("be_lhu_sel", 32'(cap_sel_be), 32'hC);
    chk("be_lhu_res", cap_res_be, 32'h00001234);

    run_txn(OP_LW, 32'h6, 32'h0, 32'h0, 1); settle();
    chk("lw_mis_buscycles", cap_bus_cycles, 0);
    chk("lw_mis_latency", cap_lat, 1);
    chk("lw_mis_adel", 32'(cap_adel), 32'h1);
    chk("lw_mis_badv", cap_badv, 32'h6);
    chk("lw_mis_wreg", 32'(cap_wreg), 32'h0);

    run_txn(OP_LW, 32'h40, 32'h0, 32'hDEADBEEF, 0); settle();
    chk("timeout_buscycles", cap_bus_cycles, TO);
    chk("timeout_exc_bus", 32'(cap_exc_bus), 32'h1);

    run_txn(OP_LW, 32'h44, 32'h0, 32'hDEADBEEF, TO); settle();
    chk("ackwins_exc_bus", 32'(cap_exc_bus), 32'h0);
    chk("ackwins_res", cap_res_le, 32'hDEADBEEF);
    chk("ackwins_latency", cap_lat, TO + 1);

    for (int n = 0; n < 300; n++) begin
      run_txn(op_tbl[$urandom_range(0, 13)], $urandom, $urandom, $urandom, $urandom_range(0, 6));
    end

    // Reset asserted while a bus transfer is in flight.
    @(posedge clk); #1;
    set_idle();
    in_valid = 1'b1; op = OP_SW; addr = 32'h300; rt_data = 32'hA5A5A5A5; bus_ack = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; chk_en = 1'b0;
    @(negedge clk);
    chk("rstmid_bus_en_before", 32'(bus_en_le), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_bus_en", {30'h0, bus_en_le, bus_en_be}, 32'h0);
    chk("rstmid_in_ready", {30'h0, in_ready_le, in_ready_be}, 32'h3);
    chk("rstmid_busy", 32'(busy_le), 32'h0);
    chk("rstmid_bus_sel", 32'(bus_sel_le), 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_no_res_valid", {30'h0, res_valid_le, res_valid_be}, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b1; set_idle(); chk_en = 1'b1;
    repeat (3) @(posedge clk);

    for (int n = 0; n < 40; n++) begin
      run_txn(op_tbl[$urandom_range(0, 13)], $urandom, $urandom, $urandom, $urandom_range(0, 6));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; set_idle();
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
